// File: rtl/cpu_pkg.sv
// Shared CPU definitions: forwarding select encodings, register-index defaults
// and the destination-info slot tracked by the forwarding/hazard unit.
package cpu_pkg;

    localparam int REG_ADDR_W_DEFAULT = 5;
    // Slot rd field is sized for the widest supported register index; narrower
    // indices are zero-extended on entry, so comparisons stay exact.
    localparam int SLOT_RD_W = 8;

    localparam int FWD_REGFILE = 0;
    localparam int FWD_MEM     = 1;
    localparam int FWD_WB      = 2;

    typedef struct packed {
        logic                 valid;
        logic [SLOT_RD_W-1:0] rd;
        logic                 regwrite;
        logic                 memread;
    } slot_t;

    // x0 is hard-wired to zero, so a write to it never produces forwardable data.
    function automatic logic is_writer(input slot_t s);
        return s.valid & s.regwrite & (s.rd != '0);
    endfunction

endpackage

// File: rtl/fwd_port_sel.sv
// Per-source-port priority matcher: picks the youngest post-EX stage that
// writes the requested register, or the register file when none does.
module fwd_port_sel
    import cpu_pkg::*;
#(
    parameter int NUM_FWD_STAGES = 2,
    parameter int SEL_W          = 2
) (
    input  logic                              i_en,
    input  logic [SLOT_RD_W-1:0]              i_rs,
    input  slot_t [NUM_FWD_STAGES-1:0]        i_stages,
    output logic [SEL_W-1:0]                  o_sel
);

    // Scan oldest to youngest so the youngest matching stage wins.
    always_comb begin
        o_sel = SEL_W'(FWD_REGFILE);
        if (i_en) begin
            for (int k = NUM_FWD_STAGES - 1; k >= 0; k--) begin
                if (is_writer(i_stages[k]) && (i_stages[k].rd == i_rs)) begin
                    o_sel = SEL_W'(k + 1);
                end
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding select and load-use stall generation from a shadow pipeline of
// destination info. Define FWD_HAZARD_PERF_EN to add stall/forward counters.
module fwd_hazard_unit
    import cpu_pkg::*;
#(
    parameter int NUM_SRC          = 2,
    parameter int NUM_FWD_STAGES   = 2,
    parameter int REG_ADDR_W       = REG_ADDR_W_DEFAULT,
    parameter int LOAD_READY_STAGE = 2,
    localparam int SEL_W           = $clog2(NUM_FWD_STAGES + 1)
) (
    input  logic                          clk,
    input  logic                          arst_n,
    input  logic                          advance,
    input  logic                          flush_ex,
    input  logic                          id_valid,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] id_rs,
    input  logic [NUM_SRC-1:0]            id_rs_used,
    input  logic [REG_ADDR_W-1:0]         id_rd,
    input  logic                          id_regwrite,
    input  logic                          id_memread,
    output logic [NUM_SRC*SEL_W-1:0]      fwd_sel,
    output logic                          stall_id
`ifdef FWD_HAZARD_PERF_EN
    ,
    output logic [31:0]                   perf_stall_cnt,
    output logic [31:0]                   perf_fwd_cnt
`endif
);

    slot_t                         r_ex;
    logic [NUM_SRC*REG_ADDR_W-1:0] r_ex_rs;
    logic [NUM_SRC-1:0]            r_ex_rs_used;
    slot_t [NUM_FWD_STAGES-1:0]    r_stage;

    slot_t w_id_slot;
    logic  w_bubble;
    logic  w_load_hit;

    always_comb begin
        w_id_slot          = '0;
        w_id_slot.valid    = 1'b1;
        w_id_slot.rd       = SLOT_RD_W'(id_rd);
        w_id_slot.regwrite = id_regwrite;
        w_id_slot.memread  = id_memread;
    end

    // A load in EX or in any stage before LOAD_READY_STAGE-1 cannot supply
    // data in time for the instruction currently in ID.
    always_comb begin
        w_load_hit = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (id_rs_used[i]) begin
                if (is_writer(r_ex) && r_ex.memread &&
                    (r_ex.rd == SLOT_RD_W'(id_rs[i*REG_ADDR_W +: REG_ADDR_W]))) begin
                    w_load_hit = 1'b1;
                end
                for (int k = 1; k < LOAD_READY_STAGE - 1; k++) begin
                    if (is_writer(r_stage[k-1]) && r_stage[k-1].memread &&
                        (r_stage[k-1].rd == SLOT_RD_W'(id_rs[i*REG_ADDR_W +: REG_ADDR_W]))) begin
                        w_load_hit = 1'b1;
                    end
                end
            end
        end
    end

    assign stall_id = id_valid & w_load_hit;
    assign w_bubble = flush_ex | stall_id | ~id_valid;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_ex         <= '0;
            r_ex_rs      <= '0;
            r_ex_rs_used <= '0;
            r_stage      <= '0;
        end else if (advance) begin
            r_stage[0] <= r_ex;
            for (int k = 1; k < NUM_FWD_STAGES; k++) begin
                r_stage[k] <= r_stage[k-1];
            end
            r_ex         <= w_bubble ? '0 : w_id_slot;
            r_ex_rs      <= w_bubble ? '0 : id_rs;
            r_ex_rs_used <= w_bubble ? '0 : id_rs_used;
        end
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_port
        logic [SLOT_RD_W-1:0] w_rs;
        assign w_rs = SLOT_RD_W'(r_ex_rs[i*REG_ADDR_W +: REG_ADDR_W]);

        fwd_port_sel #(
            .NUM_FWD_STAGES (NUM_FWD_STAGES),
            .SEL_W          (SEL_W)
        ) u_port_sel (
            .i_en     (r_ex.valid & r_ex_rs_used[i]),
            .i_rs     (w_rs),
            .i_stages (r_stage),
            .o_sel    (fwd_sel[i*SEL_W +: SEL_W])
        );
    end

`ifdef FWD_HAZARD_PERF_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_fwd;
    logic        w_any_fwd;

    assign w_any_fwd = r_ex.valid & (|fwd_sel);

    // Both counters saturate rather than wrap.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_perf_stall <= '0;
            r_perf_fwd   <= '0;
        end else begin
            if (advance && stall_id && (r_perf_stall != 32'hFFFF_FFFF)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
            if (advance && w_any_fwd && (r_perf_fwd != 32'hFFFF_FFFF)) begin
                r_perf_fwd <= r_perf_fwd + 32'd1;
            end
        end
    end

    assign perf_stall_cnt = r_perf_stall;
    assign perf_fwd_cnt   = r_perf_fwd;
`endif

endmodule
